unified_mem_arbiter: RTL

- Shares one single-port unified memory between the IF fetch port and the MEM-stage data port of the 5-stage RISC-V pipeline.
- Arbitrates requests and sequences each transaction with a req/ready handshake.
- Drives if_stall/dm_stall into the hazard unit's PC/IF-ID/pipeline enables.
- Discards wrong-path fetches on branch flush and flags hung memory via a timeout.

---
 rtl/unified_mem_arbiter_if.sv | 51 +++++
 rtl/unified_mem_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch port, data port and memory port of the unified memory arbiter.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [STRB_W-1:0] dm_wmask;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wmask;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport master (
    input  if_req, if_addr, if_flush,
    output if_valid, if_rdata, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
    output dm_valid, dm_rdata, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rdata
  );

  // Pipeline and memory side
  modport slave (
    output if_req, if_addr, if_flush,
    input  if_valid, if_rdata, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
    input  dm_valid, dm_rdata, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the IF fetch port and MEM data port onto one single-port memory,
// with flush-drop of wrong-path fetches and a sticky hung-memory timeout.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  unified_mem_arbiter_if.master bus,
  output logic                  err
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, DATA, INST, DROP, ERR} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wmask_q, mem_wmask_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  // A port whose valid is pulsing this cycle is not re-arbitrated: its req is still up.
  logic dm_take, if_take, done;
  assign dm_take = bus.dm_req && !dm_valid_q;
  assign if_take = bus.if_req && !if_valid_q && !bus.if_flush;
  assign done    = mem_req_q && bus.mem_ready;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    dm_valid_d  = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (dm_take) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          mem_wmask_d = bus.dm_wmask;
          cnt_d       = '0;
        end else if (if_take) begin
          state_d     = INST;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
          cnt_d       = '0;
        end
      end
      DATA, INST, DROP: begin
        if (done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == DATA) begin
            dm_valid_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
          end else if (state_q == INST && !bus.if_flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ERR;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == INST && bus.if_flush) state_d = DROP;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      dm_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      dm_valid_q  <= dm_valid_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign err           = err_q;

  // Stalls release in the same cycle the matching valid pulses.
  assign bus.dm_stall = bus.dm_req && !dm_valid_q;
  assign bus.if_stall = bus.if_req && !if_valid_q;
endmodule
